// File: rtl/baud_gen_frac.sv
// Fractional-divisor baud generator: oversample tick, mid-bit sample strobe and
// bit-boundary strobe, with a double-buffered runtime divisor and phase resync.
module baud_gen_frac #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 39
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          bps_en,
    input  logic                          resync,
    input  logic [DIV_W-1:0]              div_int,
    input  logic [FRAC_W-1:0]             div_frac,
    input  logic                          div_load,
    output logic                          load_pend,
    output logic                          os_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          bps_clk,
    output logic                          bit_end
);

    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  div_int_reg, pend_int_reg;
    logic [FRAC_W-1:0] div_frac_reg, pend_frac_reg;
    logic              load_pend_reg;
    logic [FRAC_W-1:0] acc_reg;
    logic [DIV_W:0]    cnt_reg, len_reg;
    logic [PH_W-1:0]   phase_reg;
    logic              os_tick_reg, bps_clk_reg, bit_end_reg;

    logic              running;
    logic              terminal;
    logic              period_start;
    logic              at_bit_end;
    logic              apply;
    logic [DIV_W-1:0]  cap_int;
    logic [DIV_W-1:0]  int_eff;
    logic [FRAC_W-1:0] frac_eff;
    logic [FRAC_W:0]   frac_sum;
    logic [DIV_W:0]    len_next;

    always_comb begin
        running      = bps_en && !resync;
        // cnt_reg == 0 only while idle or just after a resync: that cycle opens a period
        terminal     = running && (cnt_reg != '0) && (cnt_reg == len_reg);
        period_start = running && ((cnt_reg == '0) || terminal);
        at_bit_end   = terminal && (phase_reg == PH_LAST);
        apply        = load_pend_reg && (!bps_en || resync || at_bit_end);
        cap_int      = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
        int_eff      = apply ? pend_int_reg  : div_int_reg;
        frac_eff     = apply ? pend_frac_reg : div_frac_reg;
        frac_sum     = {1'b0, acc_reg} + {1'b0, frac_eff};
        len_next     = {1'b0, int_eff} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            div_int_reg   <= DIV_W'(DEFAULT_DIV);
            div_frac_reg  <= '0;
            pend_int_reg  <= DIV_W'(DEFAULT_DIV);
            pend_frac_reg <= '0;
            load_pend_reg <= 1'b0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            len_reg       <= '0;
            phase_reg     <= '0;
            os_tick_reg   <= 1'b0;
            bps_clk_reg   <= 1'b0;
            bit_end_reg   <= 1'b0;
        end else begin
            if (apply) begin
                div_int_reg  <= pend_int_reg;
                div_frac_reg <= pend_frac_reg;
            end
            // A capture coinciding with an apply point stays pending for the next one
            if (div_load) begin
                pend_int_reg  <= cap_int;
                pend_frac_reg <= div_frac;
                load_pend_reg <= 1'b1;
            end else if (apply) begin
                load_pend_reg <= 1'b0;
            end

            if (!running) begin
                cnt_reg     <= '0;
                acc_reg     <= '0;
                phase_reg   <= '0;
                os_tick_reg <= 1'b0;
                bps_clk_reg <= 1'b0;
                bit_end_reg <= 1'b0;
            end else begin
                os_tick_reg <= terminal;
                bps_clk_reg <= terminal && (phase_reg == PH_MID);
                bit_end_reg <= at_bit_end;
                if (terminal) begin
                    phase_reg <= phase_reg + PH_W'(1);
                end
                if (period_start) begin
                    acc_reg <= frac_sum[FRAC_W-1:0];
                    len_reg <= len_next;
                    cnt_reg <= (DIV_W + 1)'(1);
                end else begin
                    cnt_reg <= cnt_reg + (DIV_W + 1)'(1);
                end
            end
        end
    end

    assign load_pend = load_pend_reg;
    assign os_tick   = os_tick_reg;
    assign os_phase  = phase_reg;
    assign bps_clk   = bps_clk_reg;
    assign bit_end   = bit_end_reg;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Directed bench for baud_gen_frac: divisor loading, fractional periods,
// resync, clamping, disable and mid-operation reset.
module tb_baud_gen_frac;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        bps_en = 1'b0;
    logic        resync = 1'b0;
    logic [15:0] div_int = '0;
    logic [3:0]  div_frac = '0;
    logic        div_load = 1'b0;
    logic        load_pend;
    logic        os_tick;
    logic [3:0]  os_phase;
    logic        bps_clk;
    logic        bit_end;

    int pass_cnt  = 0;
    int total_cnt = 0;

    baud_gen_frac dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .bps_en   (bps_en),
        .resync   (resync),
        .div_int  (div_int),
        .div_frac (div_frac),
        .div_load (div_load),
        .load_pend(load_pend),
        .os_tick  (os_tick),
        .os_phase (os_phase),
        .bps_clk  (bps_clk),
        .bit_end  (bit_end)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one edge; outputs are then sampled 1 time unit later
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Load a divisor while disabled: captured on one edge, applied on the next
    task automatic load_idle(input int d, input int f);
        bps_en   = 1'b0;
        div_int  = 16'(d);
        div_frac = 4'(f);
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        step();
        $display("load div_int=%0d div_frac=%0d (idle)", d, f);
    endtask

    initial begin
        int n;
        int tick_edge;
        int bps_seen;
        logic exp_tick;

        // ---------------- Test 1: reset and D=4 ----------------
        step();
        step();
        rst_in = 1'b0;
        check_val("rst_outputs", {28'd0, os_tick, bps_clk, bit_end, load_pend}, 32'd0);
        check_val("rst_phase", {28'd0, os_phase}, 32'd0);

        div_int = 16'd4; div_frac = 4'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        check_val("t1_pend_set", {31'd0, load_pend}, 32'd1);
        step();
        check_val("t1_pend_clr", {31'd0, load_pend}, 32'd0);
        $display("load div_int=4 div_frac=0 (idle)");

        bps_en = 1'b1;
        step();
        check_val("t1_edge0", {28'd0, os_tick, bps_clk, bit_end, 1'b0}, 32'd0);
        for (int e = 1; e <= 130; e++) begin
            step();
            exp_tick = (e % 4 == 0);
            check_val($sformatf("t1_e%0d", e),
                      {25'd0, os_tick, bps_clk, bit_end, os_phase},
                      {25'd0, exp_tick, exp_tick && ((e / 4) % 16 == 8),
                       exp_tick && ((e / 4) % 16 == 0), 4'((e / 4) % 16)});
        end

        // ---------------- Test 2: D=10 F=8 ----------------
        load_idle(10, 8);
        bps_en = 1'b1;
        step();
        n = 1;
        tick_edge = 10;
        bps_seen = 0;
        for (int e = 1; e <= 340; e++) begin
            step();
            exp_tick = (e == tick_edge);
            if (bps_clk) bps_seen++;
            check_val($sformatf("t2_e%0d", e),
                      {29'd0, os_tick, bps_clk, bit_end},
                      {29'd0, exp_tick, exp_tick && (n % 16 == 8), exp_tick && (n % 16 == 0)});
            if (exp_tick) begin
                n++;
                tick_edge = 10 * n + n / 2;
            end
        end
        check_val("t2_bps_count", 32'(bps_seen), 32'd2);

        // ---------------- Test 3: load D=6 while running D=4 ----------------
        load_idle(4, 0);
        bps_en = 1'b1;
        step();
        for (int e = 1; e <= 165; e++) begin
            if (e == 20) begin
                div_int = 16'd6; div_frac = 4'd0; div_load = 1'b1;
            end
            step();
            div_load = 1'b0;
            if (e == 20) $display("load div_int=6 div_frac=0 (running)");
            exp_tick = (e <= 64) ? (e % 4 == 0) : ((e - 64) % 6 == 0);
            check_val($sformatf("t3_e%0d", e),
                      {29'd0, os_tick, bit_end, load_pend},
                      {29'd0, exp_tick, (e == 64) || (e == 160), (e >= 20) && (e < 64)});
        end

        // ---------------- Test 4: resync ----------------
        load_idle(4, 0);
        bps_en = 1'b1;
        step();
        for (int e = 1; e <= 49; e++) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        $display("resync at edge 50");
        check_val("t4_rs50_tick", {31'd0, os_tick}, 32'd0);
        check_val("t4_rs50_phase", {28'd0, os_phase}, 32'd0);
        for (int e = 51; e <= 58; e++) begin
            step();
            check_val($sformatf("t4_e%0d", e), {31'd0, os_tick}, {31'd0, (e == 55)});
        end
        resync = 1'b1;
        step();
        resync = 1'b0;
        $display("resync at edge 59 (terminal)");
        check_val("t4_rs59_tick", {31'd0, os_tick}, 32'd0);
        check_val("t4_rs59_phase", {28'd0, os_phase}, 32'd0);
        for (int e = 60; e <= 68; e++) begin
            step();
            check_val($sformatf("t4_e%0d", e), {31'd0, os_tick}, {31'd0, (e == 64) || (e == 68)});
        end

        // ---------------- Test 5: clamp, disable, re-enable ----------------
        load_idle(0, 0);
        bps_en = 1'b1;
        step();
        for (int e = 1; e <= 6; e++) begin
            step();
            check_val($sformatf("t5a_e%0d", e), {31'd0, os_tick}, {31'd0, (e % 2 == 0)});
        end
        load_idle(1, 0);
        bps_en = 1'b1;
        step();
        for (int e = 1; e <= 5; e++) begin
            step();
            check_val($sformatf("t5b_e%0d", e), {31'd0, os_tick}, {31'd0, (e % 2 == 0)});
        end
        bps_en = 1'b0;
        step();
        check_val("t5_disable", {27'd0, os_tick, os_phase}, 32'd0);
        load_idle(5, 0);
        bps_en = 1'b1;
        step();
        for (int e = 1; e <= 6; e++) begin
            step();
            check_val($sformatf("t5c_e%0d", e), {31'd0, os_tick}, {31'd0, (e == 5)});
        end

        // ---------------- Test 6: reset mid-bit with pending load ----------------
        load_idle(5, 0);
        bps_en = 1'b1;
        step();
        for (int e = 1; e <= 9; e++) begin
            if (e == 2) begin
                div_int = 16'd7; div_frac = 4'd0; div_load = 1'b1;
            end
            step();
            div_load = 1'b0;
        end
        check_val("t6_pend_before", {31'd0, load_pend}, 32'd1);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        $display("reset at edge 10 with pending load");
        check_val("t6_rst_outputs", {28'd0, os_tick, bps_clk, bit_end, load_pend}, 32'd0);
        check_val("t6_rst_phase", {28'd0, os_phase}, 32'd0);
        for (int e = 0; e <= 40; e++) begin
            step();
            check_val($sformatf("t6_e%0d", e), {31'd0, os_tick}, {31'd0, (e == 39)});
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
